serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands.
REQ-006 SHALL have port: a  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: sum  output  WIDTH  registered result.
REQ-012 SHALL have port: cout  output  1  registered carry-out.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; encoding free.
REQ-015 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 IDLE: SHALL accept when in_valid&in_ready; capture a, b into shift registers, carry register <= cin, bit counter <= 0, next state RUN.
REQ-017 RUN: SHALL compute one full-adder bit per cycle from LSB: s = a0^b0^c, c' = a0&b0 | c&a0 | c&b0; shift s into result register from MSB side; carry <= c'; counter += 1.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the cycle counter == WIDTH-1, next state DONE and sum/cout update to the final result.
REQ-019 out_valid SHALL first be high WIDTH cycles after the accepting edge.
REQ-020 DONE: sum and cout SHALL be held stable until out_valid&out_ready; then next state IDLE.
REQ-021 No bypass: in_ready SHALL rise the cycle after the result handshake; minimum period per operation is WIDTH+2 cycles.
REQ-022 in_valid, a, b and cin SHALL be ignored outside IDLE; operand changes after acceptance SHALL not affect the result.
REQ-023 sum and cout SHALL retain the last result in IDLE and RUN until the next operation completes.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
REQ-025 Counter SHALL be ceil(log2(WIDTH)) bits minimum and SHALL not wrap within RUN.

Reset
REQ-026 rst low SHALL immediately force state IDLE, sum=0, cout=0, counter=0, carry=0, shift registers=0, regardless of clock.
REQ-027 During reset: in_ready=0, out_valid=0, busy=0; in_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-028 Reset mid-RUN or mid-DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-029 Macro SERIAL_ADD_OVF_EN defined: SHALL add output port ovf (1 bit), registered with sum, = carry into MSB XOR cout (two's-complement overflow), reset 0, held like sum.
REQ-030 Macro SERIAL_ADD_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-031 a=0x5A, b=0x33, cin=0, out_ready=1 -> sum=0x8D, cout=0, ovf=1; out_valid first high 8 cycles after accept, one cycle wide.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-034 out_ready held low 5 cycles in DONE, in_valid pulsed with new operands during RUN and DONE -> out_valid, sum, cout stable; in_ready=0; new operands not captured.
REQ-035 rst pulsed low at RUN cycle 3 -> outputs 0, busy=0 asynchronously; in_ready=1 first edge after release; no out_valid.
REQ-036 Back-to-back: in_valid and out_ready held high, 3 operations -> results in order, accepts spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial ripple adder: accepts WIDTH-bit operands, adds one bit per clock from the LSB,
// and presents the registered sum/carry. Define SERIAL_ADD_OVF_EN to add the ovf output.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [1:0]       fa_s;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q,       ovf_d;
`endif

    // Returns {carry_out, sum_bit} of a single full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic s;
        logic co;
        s  = x ^ y ^ c;
        co = (x & y) | (c & x) | (c & y);
        return {co, s};
    endfunction

    // Next-state, datapath and handshake-flag computation.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        fa_s     = full_add(a_sh_q[0], b_sh_q[0], carry_q);

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_s[1];
                res_d   = {fa_s[0], res_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the result; the counter holds rather than wrapping.
                    state_d = ST_DONE;
                    sum_d   = {fa_s[0], res_q[WIDTH-1:1]};
                    cout_d  = fa_s[1];
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_s[1];
`endif
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; in_ready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results, stall, mid-run reset and back-to-back runs.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: operation lifetime tracked as "cycles of adding left" plus a done flag.
    bit           m_live = 1'b0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;
    int           cyc      = 0;
    int           last_acc = 0;
    int           acc_q[$];

    always @(posedge clk or negedge rst) begin
        logic [W:0] full;
        if (!rst) begin
            m_live   = 1'b0;
            m_left   = 0;
            m_done   = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            cyc++;
            if (!m_live) begin
                m_live = 1'b1;
            end else if (m_done) begin
                if (out_ready) m_done = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    full     = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                    exp_sum  = full[W-1:0];
                    exp_cout = full[W];
                    exp_ovf  = (m_a[W-1] == m_b[W-1]) && (full[W-1] != m_a[W-1]);
                    m_done   = 1'b1;
                end
            end else if (in_valid) begin
                m_a      = a;
                m_b      = b;
                m_cin    = cin;
                m_left   = W;
                last_acc = cyc;
                acc_q.push_back(cyc);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_in_ready",  {31'd0, in_ready},  {31'd0, (m_live && !m_done && m_left == 0)});
        chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_done});
        chk("cyc_busy",      {31'd0, busy},      {31'd0, (m_done || m_left > 0)});
        chk("cyc_sum",       {24'd0, sum},       {24'd0, exp_sum});
        chk("cyc_cout",      {31'd0, cout},      {31'd0, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
        chk("cyc_ovf",       {31'd0, ovf},       {31'd0, exp_ovf});
`endif
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    // One directed operation with literal expected results, latency and pulse width.
    task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        int acc;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_ready(nm);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        acc = last_acc;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        wait_valid(nm);
        chk({nm, "_latency"}, cyc - acc, W);
        chk({nm, "_sum"},  {24'd0, sum},  {24'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: unexpected x in ovf literal");
`endif
        @(negedge clk);
        chk({nm, "_one_wide"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int hits;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum",      {24'd0, sum},       32'd0);
        chk("rst_in_ready", {31'd0, in_ready},  32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_outvalid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        op("op5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op("op7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op("opffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Stall in DONE with new operands offered during RUN and DONE.
        out_ready = 1'b0;
        wait_ready("stall");
        a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'hAA; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum",   {24'd0, sum},       32'h47);
            chk("stall_ready", {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("stall_after_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_retain",      {24'd0, sum},      32'h47);

        // Asynchronous reset during RUN discards the operation.
        a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_sum",      {24'd0, sum},       32'd0);
        chk("arst_cout",     {31'd0, cout},      32'd0);
        chk("arst_busy",     {31'd0, busy},      32'd0);
        chk("arst_in_ready", {31'd0, in_ready},  32'd0);
        chk("arst_outvalid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", {31'd0, in_ready}, 32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) hits++;
        end
        chk("arst_no_valid", hits, 32'd0);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 60) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_count", acc_q.size(), 32'd3);
        if (acc_q.size() >= 3) begin
            chk("b2b_space1", acc_q[1] - acc_q[0], 32'd10);
            chk("b2b_space2", acc_q[2] - acc_q[1], 32'd10);
        end

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
